// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying instruction, PC, operands, hazard T_new, exception code and validity.
// Optional macro STAGE_TNEW_DECODE_EN derives T_new from the instruction word instead of tnew_in.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int TNEW_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] ext_in,
    input  logic [4:0]        a1_in,
    input  logic [4:0]        a2_in,
    input  logic [4:0]        a3_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [4:0]        exc_in,
    input  logic              bd_in,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] ext,
    output logic [4:0]        a1,
    output logic [4:0]        a2,
    output logic [4:0]        a3,
    output logic [TNEW_W-1:0] tnew,
    output logic [4:0]        exc,
    output logic              bd,
    output logic              valid
);

    localparam logic [TNEW_W-1:0] TNEW_NONE = {TNEW_W{1'b1}};
    localparam logic [TNEW_W-1:0] TNEW_ZERO = {TNEW_W{1'b0}};
    localparam logic [4:0]        EXC_RI    = 5'd10;

`ifdef STAGE_TNEW_DECODE_EN
    localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(2'd1);
    localparam logic [TNEW_W-1:0] TNEW_TWO = TNEW_W'(2'd2);

    // Cycles until the result is ready, by instruction class; non-writers get NONE.
    function automatic logic [TNEW_W-1:0] decode_tnew(input logic [DATA_W-1:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        op = ins[31:26];
        fn = ins[5:0];
        rs = ins[25:21];
        decode_tnew = TNEW_NONE;
        if (ins == {DATA_W{1'b0}}) begin
            decode_tnew = TNEW_NONE;
        end else begin
            case (op)
                6'h00: begin
                    case (fn)
                        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                        6'h10, 6'h12,
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2a, 6'h2b: decode_tnew = TNEW_ONE;
                        6'h09:        decode_tnew = TNEW_ZERO;
                        default:      decode_tnew = TNEW_NONE;
                    endcase
                end
                6'h10:   decode_tnew = (rs == 5'd0) ? TNEW_ONE : TNEW_NONE;
                6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f:
                         decode_tnew = TNEW_ONE;
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                         decode_tnew = TNEW_TWO;
                6'h03:   decode_tnew = TNEW_ZERO;
                default: decode_tnew = TNEW_NONE;
            endcase
        end
    endfunction

    logic unused_tnew_in_s;
    assign unused_tnew_in_s = ^tnew_in;
`else
    // One stage later, the producer is one cycle closer; saturate at zero, keep NONE.
    function automatic logic [TNEW_W-1:0] next_tnew(input logic [TNEW_W-1:0] t);
        if (t == TNEW_NONE) begin
            next_tnew = TNEW_NONE;
        end else if (t == TNEW_ZERO) begin
            next_tnew = TNEW_ZERO;
        end else begin
            next_tnew = t - TNEW_W'(1'b1);
        end
    endfunction
`endif

    // Initialisers give reset values from time zero.
    logic [DATA_W-1:0] instr_q = '0, pc_q = '0, rd1_q = '0, rd2_q = '0, ext_q = '0;
    logic [4:0]        a1_q = '0, a2_q = '0, a3_q = '0, exc_q = '0;
    logic [TNEW_W-1:0] tnew_q = {TNEW_W{1'b1}};
    logic              bd_q = 1'b0, valid_q = 1'b0;

    logic [DATA_W-1:0] instr_d, pc_d, rd1_d, rd2_d, ext_d;
    logic [4:0]        a1_d, a2_d, a3_d, exc_d;
    logic [TNEW_W-1:0] tnew_d;
    logic [TNEW_W-1:0] tnew_base_s;
    logic              bd_d, valid_d;

    // Next-state selection: flush bubble, capture with overrides, or hold.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        ext_d   = ext_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        tnew_d  = tnew_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
`ifdef STAGE_TNEW_DECODE_EN
        tnew_base_s = decode_tnew(instr_in);
`else
        tnew_base_s = next_tnew(tnew_in);
`endif
        if (flush) begin
            // The bubble keeps pc/bd so an exception taken here still reports the right EPC.
            instr_d = '0;
            pc_d    = pc_in;
            rd1_d   = '0;
            rd2_d   = '0;
            ext_d   = '0;
            a1_d    = 5'd0;
            a2_d    = 5'd0;
            a3_d    = 5'd0;
            tnew_d  = TNEW_NONE;
            exc_d   = 5'd0;
            bd_d    = bd_in;
            valid_d = 1'b0;
        end else if (en) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            rd1_d   = rd1_in;
            rd2_d   = rd2_in;
            ext_d   = ext_in;
            a1_d    = a1_in;
            a2_d    = a2_in;
            a3_d    = a3_in;
            exc_d   = exc_in;
            bd_d    = bd_in;
            valid_d = 1'b1;
            if (a3_in == 5'd0) begin
                tnew_d = TNEW_NONE;
            end else begin
                tnew_d = tnew_base_s;
            end
            if (exc_in == EXC_RI) begin
                instr_d = '0;
                a3_d    = 5'd0;
                tnew_d  = TNEW_NONE;
            end else begin
                instr_d = instr_in;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ext_q   <= '0;
            a1_q    <= 5'd0;
            a2_q    <= 5'd0;
            a3_q    <= 5'd0;
            tnew_q  <= TNEW_NONE;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ext_q   <= ext_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign rd1   = rd1_q;
    assign rd2   = rd2_q;
    assign ext   = ext_q;
    assign a1    = a1_q;
    assign a2    = a2_q;
    assign a3    = a3_q;
    assign tnew  = tnew_q;
    assign exc   = exc_q;
    assign bd    = bd_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg: each record is one clock of stimulus and the state expected after it.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, bd_in;
    logic [31:0] instr_in, pc_in, rd1_in, rd2_in, ext_in;
    logic [4:0]  a1_in, a2_in, a3_in, exc_in;
    logic [2:0]  tnew_in;
    logic [31:0] instr, pc, rd1, rd2, ext;
    logic [4:0]  a1, a2, a3, exc;
    logic [2:0]  tnew;
    logic        bd, valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .TNEW_W(3)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .instr_in(instr_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .ext_in(ext_in),
        .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in), .tnew_in(tnew_in), .exc_in(exc_in), .bd_in(bd_in),
        .instr(instr), .pc(pc), .rd1(rd1), .rd2(rd2), .ext(ext),
        .a1(a1), .a2(a2), .a3(a3), .tnew(tnew), .exc(exc), .bd(bd), .valid(valid)
    );

    typedef struct {
        string       name;
        logic        rst, en, fl;
        logic [31:0] instr, pc, rd1, rd2, ext;
        logic [4:0]  a1, a2, a3;
        logic [2:0]  tn;
        logic [4:0]  exc;
        logic        bd;
        logic [31:0] e_instr, e_pc, e_rd1, e_rd2, e_ext;
        logic [4:0]  e_a1, e_a2, e_a3;
        logic [2:0]  e_tn_off, e_tn_dec;
        logic [4:0]  e_exc;
        logic        e_bd, e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic e, input logic f,
                       input logic [31:0] i, input logic [31:0] p, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] x,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                       input logic [2:0] t, input logic [4:0] c, input logic b,
                       input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ed1,
                       input logic [31:0] ed2, input logic [31:0] ex,
                       input logic [4:0] es1, input logic [4:0] es2, input logic [4:0] es3,
                       input logic [2:0] eto, input logic [2:0] etd, input logic [4:0] ec,
                       input logic eb, input logic ev);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.fl = f;
        v.instr = i; v.pc = p; v.rd1 = d1; v.rd2 = d2; v.ext = x;
        v.a1 = s1; v.a2 = s2; v.a3 = s3; v.tn = t; v.exc = c; v.bd = b;
        v.e_instr = ei; v.e_pc = ep; v.e_rd1 = ed1; v.e_rd2 = ed2; v.e_ext = ex;
        v.e_a1 = es1; v.e_a2 = es2; v.e_a3 = es3; v.e_tn_off = eto; v.e_tn_dec = etd;
        v.e_exc = ec; v.e_bd = eb; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, ".instr"}, instr, v.e_instr);
        chk({v.name, ".pc"},    pc,    v.e_pc);
        chk({v.name, ".rd1"},   rd1,   v.e_rd1);
        chk({v.name, ".rd2"},   rd2,   v.e_rd2);
        chk({v.name, ".ext"},   ext,   v.e_ext);
        chk({v.name, ".a1"},    {27'd0, a1}, {27'd0, v.e_a1});
        chk({v.name, ".a2"},    {27'd0, a2}, {27'd0, v.e_a2});
        chk({v.name, ".a3"},    {27'd0, a3}, {27'd0, v.e_a3});
`ifdef STAGE_TNEW_DECODE_EN
        chk({v.name, ".tnew"},  {29'd0, tnew}, {29'd0, v.e_tn_dec});
`else
        chk({v.name, ".tnew"},  {29'd0, tnew}, {29'd0, v.e_tn_off});
`endif
        chk({v.name, ".exc"},   {27'd0, exc}, {27'd0, v.e_exc});
        chk({v.name, ".bd"},    {31'd0, bd}, {31'd0, v.e_bd});
        chk({v.name, ".valid"}, {31'd0, valid}, {31'd0, v.e_valid});
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; flush = 1'b0; bd_in = 1'b0;
        instr_in = 32'h0; pc_in = 32'h0; rd1_in = 32'h0; rd2_in = 32'h0; ext_in = 32'h0;
        a1_in = 5'd0; a2_in = 5'd0; a3_in = 5'd0; tnew_in = 3'd0; exc_in = 5'd0;

        //   name            r  e  f  instr          pc            rd1           rd2           ext           a1 a2 a3  tn exc bd | instr          pc            rd1    rd2    ext    a1 a2 a3  off dec exc bd v
        add("reset_all",    1, 1, 1, 32'h1111_1111, 32'h0000_3000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_FFFF, 1, 2, 3, 2, 4, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 7, 7, 0, 0, 0);
        add("cap_addu",     0, 1, 0, 32'h0085_1021, 32'h3000, 32'h11, 32'h22, 32'h33, 4, 5, 8, 2, 0, 0, 32'h0085_1021, 32'h3000, 32'h11, 32'h22, 32'h33, 4, 5, 8, 1, 1, 0, 0, 1);
        add("cnt_sat0",     0, 1, 0, 32'h0085_1021, 32'h3004, 32'h11, 32'h22, 32'h33, 4, 5, 8, 0, 0, 0, 32'h0085_1021, 32'h3004, 32'h11, 32'h22, 32'h33, 4, 5, 8, 0, 1, 0, 0, 1);
        add("cnt_none",     0, 1, 0, 32'h0085_1021, 32'h3008, 32'h11, 32'h22, 32'h33, 4, 5, 8, 7, 0, 0, 32'h0085_1021, 32'h3008, 32'h11, 32'h22, 32'h33, 4, 5, 8, 7, 1, 0, 0, 1);
        add("a3_zero",      0, 1, 0, 32'h0085_1021, 32'h300C, 32'h11, 32'h22, 32'h33, 4, 5, 0, 1, 0, 0, 32'h0085_1021, 32'h300C, 32'h11, 32'h22, 32'h33, 4, 5, 0, 7, 7, 0, 0, 1);
        add("cap_ori",      0, 1, 0, 32'h3408_0001, 32'h3004, 32'h5, 32'h6, 32'h1, 0, 8, 8, 2, 0, 1, 32'h3408_0001, 32'h3004, 32'h5, 32'h6, 32'h1, 0, 8, 8, 1, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++)
            add($sformatf("stall%0d", k), 0, 0, 0, 32'hDEAD_BEEF, 32'h4000, 32'h99, 32'h98, 32'h97, 7, 7, 7, 2, 3, 0, 32'h3408_0001, 32'h3004, 32'h5, 32'h6, 32'h1, 0, 8, 8, 1, 1, 0, 1, 1);
        add("flush",        0, 0, 1, 32'hDEAD_BEEF, 32'h3008, 32'h99, 32'h98, 32'h97, 7, 7, 7, 2, 3, 1, 32'h0, 32'h3008, 32'h0, 32'h0, 32'h0, 0, 0, 0, 7, 7, 0, 1, 0);
        add("ri",           0, 1, 0, 32'hFC00_0000, 32'h3010, 32'h7, 32'h8, 32'h9, 1, 2, 9, 2, 10, 1, 32'h0, 32'h3010, 32'h7, 32'h8, 32'h9, 1, 2, 0, 7, 7, 10, 1, 1);
        add("cap_lw",       0, 1, 0, 32'h8C08_0000, 32'h3014, 32'h1, 32'h2, 32'h3, 2, 8, 8, 3, 0, 0, 32'h8C08_0000, 32'h3014, 32'h1, 32'h2, 32'h3, 2, 8, 8, 2, 2, 0, 0, 1);
        add("stall_lw",     0, 0, 0, 32'hDEAD_BEEF, 32'h4000, 32'h99, 32'h98, 32'h97, 7, 7, 7, 2, 3, 1, 32'h8C08_0000, 32'h3014, 32'h1, 32'h2, 32'h3, 2, 8, 8, 2, 2, 0, 0, 1);
        add("reset_stall",  1, 0, 0, 32'hDEAD_BEEF, 32'h4000, 32'h99, 32'h98, 32'h97, 7, 7, 7, 2, 3, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 7, 7, 0, 0, 0);
        add("cap_jal",      0, 1, 0, 32'h0C00_0C00, 32'h3018, 32'h4, 32'h5, 32'h6, 0, 0, 31, 1, 0, 1, 32'h0C00_0C00, 32'h3018, 32'h4, 32'h5, 32'h6, 0, 0, 31, 0, 0, 0, 1, 1);
        add("flush_en",     0, 1, 1, 32'h8C08_0000, 32'h301C, 32'h1, 32'h2, 32'h3, 2, 8, 8, 3, 6, 0, 32'h0, 32'h301C, 32'h0, 32'h0, 32'h0, 0, 0, 0, 7, 7, 0, 0, 0);
        add("cap_sw",       0, 1, 0, 32'hAC08_0000, 32'h3020, 32'h1, 32'h2, 32'h3, 2, 8, 8, 2, 0, 0, 32'hAC08_0000, 32'h3020, 32'h1, 32'h2, 32'h3, 2, 8, 8, 1, 7, 0, 0, 1);
        add("addu_rd0",     0, 1, 0, 32'h0085_0021, 32'h3024, 32'h1, 32'h2, 32'h3, 4, 5, 0, 2, 0, 0, 32'h0085_0021, 32'h3024, 32'h1, 32'h2, 32'h3, 4, 5, 0, 7, 7, 0, 0, 1);
        add("lw_tnew7",     0, 1, 0, 32'h8C08_0000, 32'h3028, 32'h1, 32'h2, 32'h3, 2, 8, 8, 7, 0, 0, 32'h8C08_0000, 32'h3028, 32'h1, 32'h2, 32'h3, 2, 8, 8, 7, 2, 0, 0, 1);
        add("cap_nop",      0, 1, 0, 32'h0000_0000, 32'h302C, 32'h1, 32'h2, 32'h3, 0, 0, 8, 3, 0, 0, 32'h0000_0000, 32'h302C, 32'h1, 32'h2, 32'h3, 0, 0, 8, 2, 7, 0, 0, 1);

        // Outputs must already hold reset values before any clock edge.
        #1;
        chk("init.instr", instr, 32'h0);
        chk("init.tnew",  {29'd0, tnew}, 32'h7);
        chk("init.valid", {31'd0, valid}, 32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            reset = vecs[k].rst; en = vecs[k].en; flush = vecs[k].fl;
            instr_in = vecs[k].instr; pc_in = vecs[k].pc; rd1_in = vecs[k].rd1;
            rd2_in = vecs[k].rd2; ext_in = vecs[k].ext;
            a1_in = vecs[k].a1; a2_in = vecs[k].a2; a3_in = vecs[k].a3;
            tnew_in = vecs[k].tn; exc_in = vecs[k].exc; bd_in = vecs[k].bd;
            @(posedge clk);
            #1;
            check_vec(vecs[k]);
        end

        // Inputs changing mid-cycle must not reach outputs before the next edge.
        en = 1'b1; reset = 1'b0; flush = 1'b0;
        instr_in = 32'h1234_5678; pc_in = 32'h5000;
        #2;
        chk("no_comb.instr", instr, 32'h0000_0000);
        chk("no_comb.pc",    pc,    32'h302C);
        @(posedge clk);
        #1;
        chk("latency.instr", instr, 32'h1234_5678);
        chk("latency.pc",    pc,    32'h5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of instruction, PC and operand fields.
REQ-002 Parameter TNEW_W, default 3: width of T_new field; all-ones encodes NONE (no pending register write).
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  capture enable; 0 = stall/hold.
REQ-006 flush  in  1  load a bubble instead of inputs.
REQ-007 instr_in, pc_in, rd1_in, rd2_in, ext_in  in  DATA_W each  upstream instruction, PC, register reads, extended immediate.
REQ-008 a1_in, a2_in, a3_in  in  5 each  rs, rt, destination register index.
REQ-009 tnew_in  in  TNEW_W  upstream T_new.
REQ-010 exc_in  in  5  exception code, bits [6:2] of Cause.
REQ-011 bd_in  in  1  instruction is in a branch delay slot.
REQ-012 instr, pc, rd1, rd2, ext  out  DATA_W each  registered copies.
REQ-013 a1, a2, a3  out  5 each; tnew  out  TNEW_W; exc  out  5; bd  out  1; valid  out  1  registered copies; valid=0 marks a bubble.

Function
REQ-014 Per cycle, update priority SHALL be reset > flush > en > hold.
REQ-015 en=1, flush=0: all fields SHALL capture their inputs; valid<=1.
REQ-016 en=0, flush=0: every output SHALL hold its value, tnew included (no countdown while stalled).
REQ-017 Capture SHALL set tnew <= NONE if tnew_in=NONE; else <= tnew_in-1, saturating at 0.
REQ-018 Capture with a3_in=0 SHALL force tnew<=NONE (no write to $0).
REQ-019 Capture with exc_in=10 (RI) SHALL load instr<=0, a3<=0, tnew<=NONE; pc, exc, bd SHALL still capture.
REQ-020 Flush (en ignored) SHALL load instr=0, rd1=rd2=ext=0, a1=a2=a3=0, tnew=NONE, exc=0, valid=0; pc<=pc_in and bd<=bd_in so a bubble carries the EPC.
REQ-021 Outputs SHALL be driven directly from registers: no combinational path from any input to any output.
REQ-022 Latency SHALL be exactly one cycle from capturing edge to outputs.

Reset
REQ-023 reset=1 at posedge SHALL clear all outputs to 0 except tnew=NONE; valid=0.
REQ-024 Reset asserted simultaneously with flush or en SHALL win; reset mid-stall SHALL discard held contents.
REQ-025 Outputs SHALL also start at reset values at time 0 (simulation initialisation).

Configuration
REQ-026 Macro STAGE_TNEW_DECODE_EN defined: tnew_in SHALL be ignored and an internal decoder SHALL derive T_new from instr_in, loaded without decrement.
REQ-027 Decoder: ALU R-type, shifts, slt/sltu, mfhi/mflo, mfc0 and ALU-immediate (ori, xori, andi, slti, sltiu, addi, addiu, lui) -> 1; lw/lb/lbu/lh/lhu -> 2; jal/jalr -> 0; branches, stores, j, jr, mult/div family, mthi/mtlo, mtc0, eret, nop (all-zero word) and unknown opcodes -> NONE.
REQ-028 REQ-018 and REQ-019 overrides SHALL apply after decode.
REQ-029 Macro undefined: REQ-017 SHALL apply and the decoder SHALL be absent.

Verification
REQ-030 Reset: set reset=1 for 1 cycle with all inputs driven nonzero -> all outputs 0, tnew=7, valid=0.
REQ-031 Countdown (macro off): drive en=1, tnew_in=2, a3_in=8 -> tnew=1; then tnew_in=0 -> tnew=0; then tnew_in=7 -> tnew=7.
REQ-032 Stall then flush: capture instr_in=0x34080001; hold en=0 for 3 cycles -> outputs unchanged; then flush=1 with pc_in=0x3008 -> instr=0, valid=0, pc=0x3008.
REQ-033 RI: drive en=1, exc_in=10, instr_in=0xFC000000, pc_in=0x3010 -> instr=0, a3=0, tnew=7, exc=10, pc=0x3010.
REQ-034 Macro on: lw -> tnew=2; addu with rd=3 -> 1; jal -> 0; sw -> 7; addu with rd=0 -> 7.
REQ-035 Priority: drive reset=1, flush=1, en=1 together -> reset values; then flush=1, en=1 -> bubble.
